// File: rtl/ternary_pkg.sv
// ternary_pkg: shared codes, geometry field offsets and loader state type
package ternary_pkg;
   localparam logic [1:0] TERN_ZERO = 2'b00;
   localparam logic [1:0] TERN_POS  = 2'b01;
   localparam logic [1:0] TERN_NEG  = 2'b11;
   localparam logic [1:0] TERN_ILL  = 2'b10;
   localparam int WPW         = 8;
   localparam int IN_LEN_LSB  = 3;
   localparam int OUT_LEN_LSB = 0;
   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE} ld_state_e;
endpackage

// File: rtl/ternary_word_unpack.sv
// ternary_word_unpack: splits a host word into sanitised weights with a column mask
module ternary_word_unpack
   import ternary_pkg::*;
(
   input  logic [15:0] word_i,
   input  logic [3:0]  ncol_i,
   output logic [15:0] w_o,
   output logic [7:0]  mask_o,
   output logic        ill_o
);
   logic [1:0] c;
   logic       m;
   always_comb begin
      w_o    = '0;
      mask_o = '0;
      ill_o  = 1'b0;
      c      = TERN_ZERO;
      m      = 1'b0;
      for (int j = 0; j < WPW; j++) begin
         c = word_i[2*j +: 2];
         m = 4'(j) < ncol_i;
         mask_o[j] = m;
         w_o[2*j +: 2] = (m && c != TERN_ILL) ? c : TERN_ZERO;
         ill_o = ill_o | (m && c == TERN_ILL);
      end
   end
endmodule

// File: rtl/ternary_weight_loader.sv
// ternary_weight_loader: assembles streamed ternary words into the flat weight matrix
module ternary_weight_loader
   import ternary_pkg::*;
#(
   parameter int MAX_IN_LEN  = 16,
   parameter int MAX_OUT_LEN = 8
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              ena,
   input  logic                              ui_valid,
   input  logic [15:0]                       ui_input,
   input  logic [6:0]                        ui_param,
   output logic [2*MAX_IN_LEN*MAX_OUT_LEN-1:0] uo_weights,
   output logic                              uo_done,
   output logic                              uo_busy,
   output logic                              uo_err
);
   localparam int NW = 2*MAX_IN_LEN*MAX_OUT_LEN;
   localparam int IW = $clog2(NW);
   localparam logic [4:0] MAXI = 5'(MAX_IN_LEN);
   localparam logic [3:0] MAXO = 4'(MAX_OUT_LEN);

   ld_state_e       state_q, state_d;
   logic [NW-1:0]   weights_q, weights_d;
   logic [6:0]      param_q, param_d;
   logic [3:0]      row_q, row_d;
   logic [1:0]      wcnt_q, wcnt_d;
   logic            err_q, err_d, done_q, done_d;
   logic [6:0]      param;
   logic [4:0]      in_raw, in_len, rem;
   logic [3:0]      out_raw, out_len, ncol;
   logic [1:0]      wpr;
   logic [IW-1:0]   base;
   logic [15:0]     wsan;
   logic [7:0]      mask;
   logic            ill, accept, last;

   // the entry cycle must already use the live parameter for word 0
   assign param   = (state_q == ST_IDLE) ? ui_param : param_q;
   assign in_raw  = {1'b0, param[IN_LEN_LSB +: 4]} + 5'd1;
   assign out_raw = {1'b0, param[OUT_LEN_LSB +: 3]} + 4'd1;
   assign in_len  = (in_raw > MAXI) ? MAXI : in_raw;
   assign out_len = (out_raw > MAXO) ? MAXO : out_raw;
   assign wpr     = 2'((in_len + 5'd7) >> 3);
   assign rem     = in_len - {wcnt_q, 3'b000};
   assign ncol    = (rem > 5'd8) ? 4'd8 : rem[3:0];
   assign base    = IW'(2*(int'(row_q)*MAX_IN_LEN + int'(wcnt_q)*WPW));
   assign accept  = ena & ui_valid & (state_q != ST_DONE);
   assign last    = (row_q == out_len - 4'd1) & (wcnt_q == wpr - 2'd1);

   ternary_word_unpack u_unpack (
      .word_i (ui_input),
      .ncol_i (ncol),
      .w_o    (wsan),
      .mask_o (mask),
      .ill_o  (ill)
   );

   always_comb begin
      state_d   = state_q;
      weights_d = weights_q;
      param_d   = param_q;
      row_d     = row_q;
      wcnt_d    = wcnt_q;
      err_d     = err_q;
      done_d    = 1'b0;
      case (state_q)
         ST_IDLE: if (ena) begin
            state_d   = ST_LOAD;
            param_d   = ui_param;
            weights_d = '0;
            err_d     = 1'b0;
         end
         ST_LOAD: if (!ena) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
            row_d   = '0;
            wcnt_d  = '0;
         end
         default: if (!ena) state_d = ST_IDLE;
      endcase
      // write after the clear so a word in the entry cycle survives it
      if (accept) begin
         for (int j = 0; j < WPW; j++)
            if (mask[j]) weights_d[base + IW'(2*j) +: 2] = wsan[2*j +: 2];
         err_d = err_d | ill;
         if (last) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            row_d   = '0;
            wcnt_d  = '0;
         end else if (wcnt_q == wpr - 2'd1) begin
            wcnt_d = '0;
            row_d  = row_q + 4'd1;
         end else begin
            wcnt_d = wcnt_q + 2'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         weights_q <= '0;
         param_q   <= '0;
         row_q     <= '0;
         wcnt_q    <= '0;
         err_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         weights_q <= weights_d;
         param_q   <= param_d;
         row_q     <= row_d;
         wcnt_q    <= wcnt_d;
         err_q     <= err_d;
         done_q    <= done_d;
      end
   end

   assign uo_weights = weights_q;
   assign uo_done    = done_q;
   assign uo_err     = err_q;
   assign uo_busy    = (state_q == ST_LOAD) | ((state_q == ST_IDLE) & ena);
endmodule

// File: tb/tb_ternary_weight_loader.sv
// tb_ternary_weight_loader: directed loads with a done-pulse scoreboard
module tb_ternary_weight_loader;
   localparam int NW = 256;
   logic clk = 1'b0, rst_n = 1'b0, ena = 1'b0, ui_valid = 1'b0;
   logic [15:0] ui_input = '0;
   logic [6:0]  ui_param = '0;
   logic [NW-1:0] uo_weights;
   logic uo_done, uo_busy, uo_err;

   typedef struct {logic [NW-1:0] w; logic err; int cyc;} exp_t;
   exp_t sb[$];
   exp_t e;
   int vecs = 0, miss = 0, cyc = 0, ndone = 0;
   logic [NW-1:0] ew;

   ternary_weight_loader dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .ui_valid(ui_valid),
      .ui_input(ui_input), .ui_param(ui_param), .uo_weights(uo_weights),
      .uo_done(uo_done), .uo_busy(uo_busy), .uo_err(uo_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [NW-1:0] act, input logic [NW-1:0] exp);
      vecs++;
      if (act !== exp) begin
         miss++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic expect_done(input logic [NW-1:0] w, input logic err);
      exp_t x;
      x.w = w; x.err = err; x.cyc = cyc + 1;
      sb.push_back(x);
   endtask

   task automatic send(input logic [15:0] w);
      ui_valid = 1'b1; ui_input = w;
      @(negedge clk);
      ui_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      if (uo_done === 1'b1) begin
         ndone++;
         if (sb.size() == 0) begin
            vecs++; miss++;
            $display("FAIL unexpected_done at cycle %0d", cyc);
         end else begin
            e = sb.pop_front();
            chk("done_weights", uo_weights, e.w);
            chk("done_err", uo_err, e.err);
            chk("done_latency", cyc, e.cyc);
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_weights", uo_weights, '0);
      chk("rst_done", uo_done, 0);
      chk("rst_busy", uo_busy, 0);
      chk("rst_err", uo_err, 0);
      rst_n = 1'b1;
      @(negedge clk);
      // full 16x8 matrix of +1
      ui_param = 7'h7F; ena = 1'b1; #1;
      chk("busy_entry", uo_busy, 1);
      for (int i = 0; i < 16; i++) begin
         if (i == 15) expect_done({128{2'b01}}, 1'b0);
         send(16'h5555);
      end
      chk("busy_in_done", uo_busy, 0);
      repeat (2) @(negedge clk);
      ena = 1'b0; @(negedge clk);
      // 4x2 with stalls, upper bytes discarded
      ui_param = 7'h19; ena = 1'b1;
      repeat (2) @(negedge clk);
      send(16'hFF5D);
      repeat (2) @(negedge clk);
      ew = '0; ew[7:0] = 8'h5D; ew[39:32] = 8'hC1;
      expect_done(ew, 1'b0);
      send(16'h00C1);
      ena = 1'b0; @(negedge clk);
      // single-word 8x1 with an illegal code at j=2
      ui_param = 7'h38; ena = 1'b1;
      ew = '0; ew[15:0] = 16'h0001;
      expect_done(ew, 1'b1);
      send(16'h0021);
      ena = 1'b0; @(negedge clk);
      chk("err_sticky_idle", uo_err, 1);
      @(negedge clk);
      chk("err_sticky_idle2", uo_err, 1);
      chk("hold_weights_idle", uo_weights, ew);
      // abort after 3 of 16 words
      ui_param = 7'h7F; ena = 1'b1;
      send(16'hFFFF);
      chk("err_cleared_on_start", uo_err, 0);
      chk("busy_load", uo_busy, 1);
      send(16'h5555);
      send(16'hD7C1);
      ena = 1'b0; @(negedge clk);
      ew = '0; ew[47:0] = 48'hD7C1_5555_FFFF;
      chk("abort_busy", uo_busy, 0);
      chk("abort_err", uo_err, 1);
      chk("abort_weights", uo_weights, ew);
      chk("abort_done", uo_done, 0);
      @(negedge clk);
      chk("abort_done2", uo_done, 0);
      // new load clears, then ena held high after done
      ui_param = 7'h38; ena = 1'b1;
      @(negedge clk);
      chk("clear_weights", uo_weights, '0);
      chk("clear_err", uo_err, 0);
      ew = '0; ew[15:0] = 16'h5555;
      expect_done(ew, 1'b0);
      send(16'h5555);
      ui_valid = 1'b1; ui_input = 16'hFFFF;
      repeat (8) @(negedge clk);
      chk("no_reload_weights", uo_weights, ew);
      chk("no_reload_busy", uo_busy, 0);
      ui_valid = 1'b0; ena = 1'b0; @(negedge clk);
      // reset in the middle of a load
      ui_param = 7'h7F; ena = 1'b1;
      send(16'hFFFF);
      send(16'hFFFF);
      rst_n = 1'b0; @(negedge clk);
      chk("midrst_weights", uo_weights, '0);
      chk("midrst_err", uo_err, 0);
      chk("midrst_done", uo_done, 0);
      ena = 1'b0; rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("done_count", ndone, 4);
      chk("sb_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end
endmodule
